// File: rtl/processor_nios2_qsys_0_jtag_debug_host_scan.sv
// Host-side virtual-JTAG scan engine: runs one IR update plus a full DR
// capture/shift/update per command and returns the tdo bits shifted out.
module processor_nios2_qsys_0_jtag_debug_host_scan #(
    parameter int DR_W    = 38,
    parameter int TCK_DIV = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_ir,
    input  logic            cmd_skip_ir,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DR_W-1:0] rsp_data,
    output logic            tck,
    output logic            tdi,
    input  logic            tdo,
    output logic [1:0]      ir_in,
    output logic            vs_uir,
    output logic            vs_cdr,
    output logic            vs_sdr,
    output logic            vs_udr,
    output logic            jtag_state_rti,
    output logic [2:0]      state_dbg
);

    localparam int PH_W = $clog2(2 * TCK_DIV);
    localparam int BC_W = (DR_W > 1) ? $clog2(DR_W) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * TCK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(TCK_DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
    } state_t;

    state_t          state;
    logic [PH_W-1:0] ph;
    logic [BC_W-1:0] bcnt;
    logic [DR_W-1:0] sr;

    assign state_dbg = state;

    // Both ports are valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both high; the sender holds valid (and data) until then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            ph             <= '0;
            bcnt           <= '0;
            sr             <= '0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= 2'b00;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        sr        <= cmd_dr;
                        cmd_ready <= 1'b0;
                        ph        <= '0;
                        tck       <= 1'b0;
                        if (cmd_skip_ir) begin
                            state  <= S_CDR;
                            vs_cdr <= 1'b1;
                        end else begin
                            state  <= S_UIR;
                            vs_uir <= 1'b1;
                            ir_in  <= cmd_ir;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    if (ph != PH_LAST) begin
                        ph  <= ph + PH_W'(1);
                        tck <= (ph >= PH_RISE);
                        // tck rises after this edge, so this is the tdo sample point
                        if (state == S_SDR && ph == PH_RISE)
                            rsp_data <= {tdo, rsp_data[DR_W-1:1]};
                    end else begin
                        ph  <= '0;
                        tck <= 1'b0;
                        case (state)
                            S_UIR: begin
                                vs_uir <= 1'b0;
                                vs_cdr <= 1'b1;
                                state  <= S_CDR;
                            end
                            S_CDR: begin
                                vs_cdr <= 1'b0;
                                vs_sdr <= 1'b1;
                                bcnt   <= '0;
                                tdi    <= sr[0];
                                sr     <= sr >> 1;
                                state  <= S_SDR;
                            end
                            S_SDR: begin
                                if (bcnt == BIT_LAST) begin
                                    vs_sdr <= 1'b0;
                                    vs_udr <= 1'b1;
                                    tdi    <= 1'b0;
                                    state  <= S_UDR;
                                end else begin
                                    bcnt <= bcnt + BC_W'(1);
                                    tdi  <= sr[0];
                                    sr   <= sr >> 1;
                                end
                            end
                            S_UDR: begin
                                vs_udr         <= 1'b0;
                                jtag_state_rti <= 1'b1;
                                state          <= S_RTI;
                            end
                            S_RTI: begin
                                jtag_state_rti <= 1'b0;
                                rsp_valid      <= 1'b1;
                                state          <= S_RESP;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_processor_nios2_qsys_0_jtag_debug_host_scan.sv
// Bench for the host scan engine: directed scenarios plus random commands
// against a period-level model of the scan sequence and tdo source.
module tb_processor_nios2_qsys_0_jtag_debug_host_scan;

    localparam int DR_W    = 38;
    localparam int TCK_DIV = 2;
    localparam int PER     = 2 * TCK_DIV;

    logic            clk, reset;
    logic            cmd_valid, cmd_ready, cmd_skip_ir;
    logic [1:0]      cmd_ir, ir_in;
    logic [DR_W-1:0] cmd_dr, rsp_data;
    logic            rsp_valid, rsp_ready;
    logic            tck, tdi, tdo;
    logic            vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
    logic [2:0]      state_dbg;

    processor_nios2_qsys_0_jtag_debug_host_scan #(.DR_W(DR_W), .TCK_DIV(TCK_DIV)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_skip_ir(cmd_skip_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0, viol = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // debug-module stand-in: loopback or a fixed per-period tdo pattern
    logic            tdo_mode;
    logic [DR_W-1:0] tdo_pat;
    int              rise_cnt;
    always @(posedge tck) if (vs_sdr) rise_cnt++;
    assign tdo = tdo_mode ? ((rise_cnt < DR_W) ? tdo_pat[rise_cnt] : 1'b0) : tdi;

    // strobe-run monitor: records (strobe, length) runs and protocol violations
    logic [15:0] exp_q[$], obs_q[$];
    int          last_code = 0, run_len = 0, uir_cnt = 0, prev_code = 0;
    logic [1:0]  uir_ir;
    logic        prev_tdi = 1'b0;

    always @(negedge clk) begin : mon
        int c, n;
        n = int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(jtag_state_rti);
        c = vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : vs_udr ? 4 : jtag_state_rti ? 5 : 0;
        if (n > 1) viol++;
        if (n == 0 && tck === 1'b1) viol++;
        if (tck === 1'b1 && (c != prev_code || tdi !== prev_tdi)) viol++;
        if (c != last_code) begin
            if (last_code != 0) obs_q.push_back({4'(last_code), 12'(run_len)});
            if (c == 1) begin
                uir_cnt++;
                uir_ir = ir_in;
            end
            run_len   = 1;
            last_code = c;
        end else begin
            run_len++;
        end
        prev_code = c;
        prev_tdi  = tdi;
    end

    // reference model state
    logic [1:0]      m_ir = 2'b00;
    logic            m_skip;
    logic [DR_W-1:0] m_exp;

    task automatic setup(input logic [1:0] ir, input logic skip, input logic [DR_W-1:0] dr,
                         input logic mode, input logic [DR_W-1:0] pat);
        tdo_mode = mode;
        tdo_pat  = pat;
        rise_cnt = 0;
        obs_q.delete();
        exp_q.delete();
        uir_cnt  = 0;
        m_skip   = skip;
        if (!skip) m_ir = ir;
        m_exp    = mode ? pat : dr;
        if (!skip) exp_q.push_back({4'd1, 12'(PER)});
        exp_q.push_back({4'd2, 12'(PER)});
        exp_q.push_back({4'd3, 12'(DR_W * PER)});
        exp_q.push_back({4'd4, 12'(PER)});
        exp_q.push_back({4'd5, 12'(PER)});
        cmd_ir      = ir;
        cmd_skip_ir = skip;
        cmd_dr      = dr;
    endtask

    // driver: called at a negedge; returns at the negedge after the accept edge
    task automatic issue();
        int w = 0;
        rsp_ready = 1'b0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w == 100) check("ready_timeout", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (rsp_valid !== 1'b1 && lat < 4000);
        if (rsp_valid !== 1'b1) check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic check_result(input int lat);
        @(posedge clk);
        @(negedge clk);
        check("latency", lat, (DR_W + (m_skip ? 3 : 4)) * PER);
        check("rsp_data", rsp_data, m_exp);
        check("rsp_hold", {63'd0, rsp_valid}, 64'd1);
        check("sdr_rises", rise_cnt, DR_W);
        check("ir_in", ir_in, m_ir);
        check("uir_pulses", uir_cnt, m_skip ? 0 : 1);
        if (!m_skip) check("ir_at_uir", uir_ir, m_ir);
        check("seq_len", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check("seq_run", (i < obs_q.size()) ? obs_q[i] : 16'h0, exp_q[i]);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", {63'd0, rsp_valid}, 64'd0);
        check("ready_back", {63'd0, cmd_ready}, 64'd1);
        check("rsp_stable_after", rsp_data, m_exp);
    endtask

    function automatic logic [DR_W-1:0] rnd_dr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DR_W-1:0];
    endfunction

    function automatic logic strobes_any();
        return vs_uir | vs_cdr | vs_sdr | vs_udr | jtag_state_rti;
    endfunction

    initial begin
        int lat, bad, w;
        logic [DR_W-1:0] d0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_skip_ir = 1'b0;
        cmd_dr = '0; rsp_ready = 1'b0; tdo_mode = 1'b0; tdo_pat = '0; rise_cnt = 0;
        #1 reset = 1'b1;
        #2;
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_tck_tdi", {62'd0, tck, tdi}, 64'd0);
        check("rst_ir_in", ir_in, 64'd0);
        check("rst_strobes", {63'd0, strobes_any()}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // idle for 100 cycles
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cmd_ready !== 1'b1 || tck !== 1'b0 || ir_in !== 2'b00 ||
                strobes_any() !== 1'b0 || rsp_valid !== 1'b0) bad++;
        end
        check("idle_100", bad, 0);

        // loopback
        setup(2'b01, 1'b0, 38'h2A_5A5A_5A5A, 1'b0, '0);
        issue();
        wait_rsp(lat);
        check_result(lat);
        finish_rsp();

        // debug-module pattern with zero shift-in
        setup(2'b10, 1'b0, '0, 1'b1, 38'h3F_0000_0001);
        issue();
        wait_rsp(lat);
        check_result(lat);
        finish_rsp();

        // skip IR: ir_in keeps 2'b10
        setup(2'b01, 1'b1, rnd_dr(), 1'b0, '0);
        issue();
        wait_rsp(lat);
        check_result(lat);
        finish_rsp();

        // backpressure with a held cmd_valid
        setup(2'b00, 1'b0, rnd_dr(), 1'b1, rnd_dr());
        issue();
        wait_rsp(lat);
        check_result(lat);
        setup(2'b11, 1'b0, rnd_dr(), 1'b0, '0);
        cmd_valid = 1'b1;
        d0  = rsp_data;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || cmd_ready !== 1'b0 ||
                strobes_any() !== 1'b0 || tck !== 1'b0) bad++;
        end
        check("bp_stable", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_ready_after_hs", {63'd0, cmd_ready}, 64'd1);
        check("bp_rsp_drop", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_next_accept", {63'd0, vs_uir}, 64'd1);
        wait_rsp(lat);
        check_result(lat);
        finish_rsp();

        // reset during SDR bit 20
        setup(2'b11, 1'b0, rnd_dr(), 1'b0, '0);
        issue();
        w = 0;
        while (rise_cnt < 20 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("sdr_bit20", rise_cnt, 20);
        #2 reset = 1'b1;
        #1;
        m_ir = 2'b00;
        check("mid_rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("mid_rst_tck_tdi", {62'd0, tck, tdi}, 64'd0);
        check("mid_rst_ir_in", ir_in, 64'd0);
        check("mid_rst_strobes", {63'd0, strobes_any()}, 64'd0);
        check("mid_rst_rsp", {rsp_valid, 63'(rsp_data)}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || strobes_any() !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        setup(2'b01, 1'b0, rnd_dr(), 1'b0, '0);
        issue();
        wait_rsp(lat);
        check_result(lat);
        finish_rsp();

        // random commands
        for (int i = 0; i < 10; i++) begin
            setup(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd_dr(),
                  1'($urandom_range(0, 1)), rnd_dr());
            issue();
            wait_rsp(lat);
            check_result(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_rsp();
        end

        check("protocol_viol", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/processor_nios2_qsys_0_jtag_debug_host_scan.md
# processor_nios2_qsys_0_jtag_debug_host_scan

Host-side scan engine that drives the virtual-JTAG signal set (tck, tdi, ir_in, virtual_state_uir/cdr/sdr/udr, jtag_state_rti) into the Nios II JTAG debug module and captures its tdo. It accepts one scan command at a time: a 2-bit instruction plus a DR_W-bit data word. It performs the IR update and the full DR capture/shift/update sequence, then returns the shifted-out word. It stands in for the sld_virtual_jtag_basic hub in simulation and on-chip self-test builds.

## Interface
- DR_W, 38, DR scan length in bits; matches the debug module `sr`/`jdo` width.
- TCK_DIV, 2, tck half-period in clk cycles; legal values ≥1.

- clk  input  1  system clock; every register in the block is clocked on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE.
- cmd_ir  input  2  instruction driven on ir_in.
- cmd_skip_ir  input  1  1 = skip the UIR step; ir_in keeps its previous value.
- cmd_dr  input  DR_W  data shifted out on tdi, LSB first.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  result consumed.
- rsp_data  output  DR_W  tdo bits captured; bit k = tdo of shift period k.
- tck  output  1  generated scan clock.
- tdi  output  1  scan data to the debug module.
- tdo  input  1  scan data from the debug module.
- ir_in  output  2  current virtual IR.
- vs_uir, vs_cdr, vs_sdr, vs_udr  output  1 each  virtual state strobes.
- jtag_state_rti  output  1  run-test-idle indicator.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
- Each of UIR, CDR, UDR and RTI lasts exactly one tck period. SDR lasts DR_W periods.
- A tck period is 2·TCK_DIV clk cycles:
  - tck is low for the first TCK_DIV cycles and high for the remaining TCK_DIV.
  - tck is low whenever the block is outside UIR..RTI.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready is sampled, cmd_dr is latched into the shift register and cmd_ir is latched.
  - Next state is UIR, or CDR if cmd_skip_ir=1.
- UIR: ir_in updates to the latched cmd_ir at the start of the period; vs_uir=1 for the whole period.
- CDR: vs_cdr=1 for the whole period.
- SDR: vs_sdr=1 throughout.
  - At the start of period k (k=0..DR_W-1), tdi = cmd_dr[k].
  - tdo is sampled on the clk edge at which tck rises, and stored in capture bit k.
- UDR: vs_udr=1 for the whole period; tdi=0.
- RTI: jtag_state_rti=1 for the whole period.
- RESP: rsp_valid=1 and rsp_data = capture register. Both hold until rsp_ready=1 is sampled, then the block returns to IDLE.
  - rsp_data stays stable after the handshake until the next capture begins.
- At most one strobe among vs_uir, vs_cdr, vs_sdr, vs_udr and jtag_state_rti is high at any time.
- cmd_valid is ignored outside IDLE. Command inputs are sampled only on the accept edge.

## Timing
- Reset values:
  - State IDLE, so cmd_ready=1.
  - rsp_valid=0; rsp_data=0.
  - tck=0; tdi=0; ir_in=2'b00.
  - All strobes and jtag_state_rti = 0.
  - The half-period counter is 0.
- Reset asserted mid-scan:
  - All of the above apply immediately (asynchronously).
  - The capture is discarded and no rsp_valid is produced.
  - After deassertion the block is in IDLE.
- Latency: the first strobe (vs_uir, or vs_cdr when skipping) is high in the clk cycle after the accept edge.
- rsp_valid is first high N·2·TCK_DIV cycles after the accept edge:
  - N = DR_W+4 with the UIR step (168 cycles at the defaults).
  - N = DR_W+3 when cmd_skip_ir=1 (164 cycles).
- Strobes and tdi change only in cycles where tck is low. tdo sampling coincides with the rising edge of tck.
- Back-to-back commands: earliest next accept is the cycle after the rsp handshake. A held cmd_valid is accepted then.
- rsp_ready asserted before rsp_valid has no effect. Holding rsp_valid with rsp_ready=0 stalls the block indefinitely.
- At TCK_DIV=1, tck toggles every cycle.

## Test plan
- Reset, then idle: after reset, cmd_ready=1, tck=0, ir_in=0 and all strobes are 0 for 100 cycles.
- Loopback (tdo tied to tdi), cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A:
  - ir_in=2'b01 from the first UIR cycle.
  - Exactly 38 tck rising edges occur with vs_sdr=1.
  - rsp_data=38'h2A_5A5A_5A5A, with rsp_valid first high 168 cycles after accept.
- Debug-module model returning 38'h3F_0000_0001 while cmd_dr=0:
  - rsp_data=38'h3F_0000_0001.
  - Strobe order is UIR, CDR, SDR, UDR, RTI, each one tck period except SDR.
- cmd_skip_ir=1 after a scan with ir 2'b10:
  - No vs_uir pulse; ir_in stays 2'b10.
  - rsp_valid is first high 164 cycles after accept.
- Backpressure: hold rsp_ready=0 for 50 cycles with cmd_valid held.
  - rsp_valid and rsp_data stay stable and no new command is accepted.
  - The next command is accepted the cycle after the handshake.
- Reset pulsed during SDR bit 20:
  - Outputs return to reset values immediately and no rsp_valid appears.
  - A following command completes normally with a correct rsp_data.
